// File: rtl/exec_sequencer.sv
// Single-issue sequencer: accept -> decode -> issue -> exec (start/await units) -> writeback.
// Keeps a retired-instruction count and a sticky timeout error state.
module exec_sequencer #(
  parameter int DEC_CYCLES = 2,
  parameter int ISS_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  output logic [31:0] instr_o,
  output logic        req_decode_o,
  output logic        req_issue_o,
  input  logic        alu_sel_i,
  input  logic        pc_sel_i,
  input  logic        lsu_sel_i,
  input  logic        rf_we_i,
  output logic        alu_start_o,
  output logic        pc_start_o,
  output logic        lsu_start_o,
  input  logic        alu_done_i,
  input  logic        pc_done_i,
  input  logic        lsu_done_i,
  output logic        rf_we_o,
  output logic        pc_update_o,
  output logic        busy_o,
  output logic        error_o,
  output logic [31:0] retired_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_ISSUE, S_EXEC, S_WB, S_ERROR
  } state_t;

  // One shared phase counter; width covers the largest TIMEOUT.
  localparam logic [9:0] DEC_LAST = 10'(DEC_CYCLES - 1);
  localparam logic [9:0] ISS_LAST = 10'(ISS_CYCLES - 1);
  localparam logic [9:0] TO_LAST  = 10'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [9:0]  r_cnt;
  logic [31:0] r_instr, r_retired;
  logic        r_alu_sel, r_pc_sel, r_lsu_sel, r_rf_we;
  logic        r_alu_done, r_pc_done, r_lsu_done;
  logic        w_alu_ok, w_pc_ok, w_lsu_ok, w_all_done;

  // A unit is satisfied if unselected, already done, or done this very cycle,
  // so a done on the final allowed EXEC cycle beats the timeout.
  assign w_alu_ok   = !r_alu_sel || r_alu_done || alu_done_i;
  assign w_pc_ok    = !r_pc_sel  || r_pc_done  || pc_done_i;
  assign w_lsu_ok   = !r_lsu_sel || r_lsu_done || lsu_done_i;
  assign w_all_done = w_alu_ok && w_pc_ok && w_lsu_ok;

  assign instr_o   = r_instr;
  assign retired_o = r_retired;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and decoded outputs.
  always_comb begin
    w_next        = r_state;
    instr_ready_o = 1'b0;
    req_decode_o  = 1'b0;
    req_issue_o   = 1'b0;
    alu_start_o   = 1'b0;
    pc_start_o    = 1'b0;
    lsu_start_o   = 1'b0;
    rf_we_o       = 1'b0;
    pc_update_o   = 1'b0;
    error_o       = 1'b0;
    busy_o        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) w_next = S_DECODE;
      end
      S_DECODE: begin
        req_decode_o = 1'b1;
        if (r_cnt == DEC_LAST) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        req_decode_o = 1'b1;
        req_issue_o  = 1'b1;
        if (r_cnt == ISS_LAST) w_next = S_EXEC;
      end
      S_EXEC: begin
        // r_cnt is zero only in the first EXEC cycle
        alu_start_o = r_alu_sel && (r_cnt == '0);
        pc_start_o  = r_pc_sel  && (r_cnt == '0);
        lsu_start_o = r_lsu_sel && (r_cnt == '0);
        if (w_all_done)             w_next = S_WB;
        else if (r_cnt == TO_LAST)  w_next = S_ERROR;
      end
      S_WB: begin
        rf_we_o     = r_rf_we;
        pc_update_o = 1'b1;
        w_next      = S_IDLE;
      end
      S_ERROR: error_o = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  // Phase counter, instruction latch, issue flags, sticky done flags, retire count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_instr    <= '0;
      r_retired  <= '0;
      r_alu_sel  <= 1'b0;
      r_pc_sel   <= 1'b0;
      r_lsu_sel  <= 1'b0;
      r_rf_we    <= 1'b0;
      r_alu_done <= 1'b0;
      r_pc_done  <= 1'b0;
      r_lsu_done <= 1'b0;
    end else begin
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state inside {S_DECODE, S_ISSUE, S_EXEC})
        r_cnt <= r_cnt + 10'd1;

      if (r_state == S_IDLE && instr_valid_i) r_instr <= instr_i;

      if (r_state == S_ISSUE && r_cnt == ISS_LAST) begin
        r_alu_sel  <= alu_sel_i;
        r_pc_sel   <= pc_sel_i;
        r_lsu_sel  <= lsu_sel_i;
        r_rf_we    <= rf_we_i;
        r_alu_done <= 1'b0;
        r_pc_done  <= 1'b0;
        r_lsu_done <= 1'b0;
      end

      // only selected units may set their flag, and only while executing
      if (r_state == S_EXEC) begin
        r_alu_done <= r_alu_done | (r_alu_sel & alu_done_i);
        r_pc_done  <= r_pc_done  | (r_pc_sel  & pc_done_i);
        r_lsu_done <= r_lsu_done | (r_lsu_sel & lsu_done_i);
      end

      if (r_state == S_WB) r_retired <= r_retired + 32'd1;
    end
  end

endmodule
